// File: rtl/mouse_pkg.sv
// Shared constants, types and helpers for the mouse input path.
package mouse_pkg;
    localparam int MOUSE_XW     = 10;
    localparam int MOUSE_YW     = 10;
    localparam int SCREEN_X_MAX = 799;
    localparam int SCREEN_Y_MAX = 599;
    localparam int BTN_LEFT     = 0;
    localparam int BTN_RIGHT    = 1;

    typedef struct packed {
        logic [MOUSE_XW-1:0] x;
        logic [MOUSE_YW-1:0] y;
    } mouse_pos_t;

    // Saturate an unsigned coordinate at lim; limits wider than the coordinate never clip.
    function automatic logic [31:0] clamp_u(input logic [31:0] v, input logic [31:0] lim);
        return (v > lim) ? lim : v;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: the level flips only after DEBOUNCE_CYCLES
// consecutive samples disagree with it, and a registered edge strobe fires.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    // Next-state: count disagreeing samples, toggle the level on the last one.
    always_comb begin
        level_d = level_q;
        dcnt_d  = dcnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (btn_i == level_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            level_d = ~level_q;
            dcnt_d  = '0;
            press_d = ~level_q;
            rel_d   = level_q;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    // State and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            dcnt_q  <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
endmodule

// File: rtl/mouse_param_chk.sv
// Elaboration-time legality checks for the mouse synchroniser parameters.
module mouse_param_chk #(
    parameter int SYNC_STAGES     = 2,
    parameter int STABLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 4
) ();
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be 2 or more");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be 1 or more");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be 1 or more");
    end
endmodule

// File: rtl/mouse_sync_filt.sv
// Brings asynchronous mouse position/buttons into the pixel clock domain:
// synchronise, reject torn position samples, clamp, and debounce buttons.
module mouse_sync_filt
    import mouse_pkg::*;
#(
    parameter int XW              = MOUSE_XW,
    parameter int YW              = MOUSE_YW,
    parameter int NBTN            = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int STABLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int X_MAX           = SCREEN_X_MAX,
    parameter int Y_MAX           = SCREEN_Y_MAX
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XW-1:0]   xpos_in,
    input  logic [YW-1:0]   ypos_in,
    input  logic [NBTN-1:0] btn_in,
    output logic [XW-1:0]   xpos_out,
    output logic [YW-1:0]   ypos_out,
    output logic            pos_update,
    output logic [NBTN-1:0] btn_out,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release
);
    localparam int PW = XW + YW;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE_CYCLES - 1);

    mouse_param_chk #(
        .SYNC_STAGES    (SYNC_STAGES),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chk ();

    logic [SYNC_STAGES-1:0][PW-1:0]   pos_sync_q;
    logic [SYNC_STAGES-1:0][NBTN-1:0] btn_sync_q;
    logic [PW-1:0]   s_pos;
    logic [NBTN-1:0] s_btn;

    // Per-bit synchroniser chains; each bit is metastability-hardened on its own,
    // so multi-bit coherence is restored by the stability filter below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_sync_q <= '0;
            btn_sync_q <= '0;
        end else begin
            pos_sync_q[0] <= {xpos_in, ypos_in};
            btn_sync_q[0] <= btn_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pos_sync_q[i] <= pos_sync_q[i-1];
                btn_sync_q[i] <= btn_sync_q[i-1];
            end
        end
    end

    assign s_pos = pos_sync_q[SYNC_STAGES-1];
    assign s_btn = btn_sync_q[SYNC_STAGES-1];

    logic [PW-1:0] prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] x_q, x_d, x_clamp_s;
    logic [YW-1:0] y_q, y_d, y_clamp_s;
    logic          upd_q, upd_d;
    logic          load_s;

    assign x_clamp_s = XW'(clamp_u(32'(s_pos[PW-1:YW]), 32'(X_MAX)));
    assign y_clamp_s = YW'(clamp_u(32'(s_pos[YW-1:0]), 32'(Y_MAX)));
    assign load_s    = (s_pos == prev_q) && (cnt_q == CNT_LOAD);

    // Stability counter and output load; an equal clamped value loads silently.
    always_comb begin
        cnt_d = cnt_q;
        x_d   = x_q;
        y_d   = y_q;
        upd_d = 1'b0;
        if (s_pos != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_SAT) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (load_s) begin
            x_d   = x_clamp_s;
            y_d   = y_clamp_s;
            upd_d = (x_clamp_s != x_q) || (y_clamp_s != y_q);
        end else begin
            upd_d = 1'b0;
        end
    end

    // Position filter state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            cnt_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            upd_q  <= 1'b0;
        end else begin
            prev_q <= s_pos;
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            y_q    <= y_d;
            upd_q  <= upd_d;
        end
    end

    assign xpos_out   = x_q;
    assign ypos_out   = y_q;
    assign pos_update = upd_q;

    for (genvar b = 0; b < NBTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_i    (s_btn[b]),
            .level_o  (btn_out[b]),
            .press_o  (btn_press[b]),
            .release_o(btn_release[b])
        );
    end
endmodule

// File: tb/tb_mouse_sync_filt.sv
// Scoreboard bench: stimulus queues expected strobes with their cycle numbers,
// a forked monitor pops and compares whenever the DUT strobes.
module tb_mouse_sync_filt;
    import mouse_pkg::*;

    localparam int XW = 10;
    localparam int YW = 10;
    localparam int NBTN = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XW-1:0]   xpos_in;
    logic [YW-1:0]   ypos_in;
    logic [NBTN-1:0] btn_in;
    logic [XW-1:0]   xpos_out;
    logic [YW-1:0]   ypos_out;
    logic            pos_update;
    logic [NBTN-1:0] btn_out;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] btn_release;

    mouse_sync_filt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .xpos_in    (xpos_in),
        .ypos_in    (ypos_in),
        .btn_in     (btn_in),
        .xpos_out   (xpos_out),
        .ypos_out   (ypos_out),
        .pos_update (pos_update),
        .btn_out    (btn_out),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int              cyc;
        logic            kind;
        logic [XW-1:0]   x;
        logic [YW-1:0]   y;
        logic [NBTN-1:0] lvl;
        logic [NBTN-1:0] prs;
        logic [NBTN-1:0] rel;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    function automatic void exp_pos(input int c, input logic [XW-1:0] x, input logic [YW-1:0] y);
        ev_t e;
        e = '0;
        e.cyc = c; e.kind = 1'b0; e.x = x; e.y = y;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_btn(input int c, input logic [NBTN-1:0] l,
                                    input logic [NBTN-1:0] p, input logic [NBTN-1:0] r);
        ev_t e;
        e = '0;
        e.cyc = c; e.kind = 1'b1; e.lvl = l; e.prs = p; e.rel = r;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic mon_cmp(input string nm, input ev_t o);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected strobe cycle=%0d x=%0d y=%0d lvl=%b prs=%b rel=%b, required none",
                     nm, o.cyc, o.x, o.y, o.lvl, o.prs, o.rel);
        end else begin
            e = exp_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL %s: got cycle=%0d kind=%0d x=%0d y=%0d lvl=%b prs=%b rel=%b required cycle=%0d kind=%0d x=%0d y=%0d lvl=%b prs=%b rel=%b",
                         nm, o.cyc, o.kind, o.x, o.y, o.lvl, o.prs, o.rel,
                         e.cyc, e.kind, e.x, e.y, e.lvl, e.prs, e.rel);
            end
        end
    endtask

    task automatic monitor_step();
        ev_t o;
        if (pos_update) begin
            o = '0;
            o.cyc = cyc; o.kind = 1'b0; o.x = xpos_out; o.y = ypos_out;
            mon_cmp("pos_event", o);
        end
        if ((|btn_press) || (|btn_release)) begin
            o = '0;
            o.cyc = cyc; o.kind = 1'b1; o.lvl = btn_out; o.prs = btn_press; o.rel = btn_release;
            mon_cmp("btn_event", o);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        xpos_in = '0;
        ypos_in = '0;
        btn_in  = '0;
        idle(3);
        check("reset_outputs", {xpos_out, ypos_out, pos_update, btn_out, btn_press, btn_release}, 64'd0);
        rst_n = 1'b1;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none
        idle(8);
        check("idle_after_reset", {xpos_out, ypos_out, btn_out}, 64'd0);

        // Step position
        @(negedge clk);
        xpos_in = 10'd123; ypos_in = 10'd45;
        exp_pos(cyc + 5, 10'd123, 10'd45);
        idle(12);
        check("step_drained", 64'(exp_q.size()), 64'd0);

        // Clamp, then a different out-of-range value with the same clamped result
        @(negedge clk);
        xpos_in = 10'd1000; ypos_in = 10'd700;
        exp_pos(cyc + 5, 10'd799, 10'd599);
        idle(12);
        @(negedge clk);
        xpos_in = 10'd900; ypos_in = 10'd650;
        idle(12);
        check("clamp_hold_x", 64'(xpos_out), 64'd799);
        check("clamp_drained", 64'(exp_q.size()), 64'd0);

        // Unstable bus: toggle x every cycle, then hold
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            xpos_in = (k % 2 == 0) ? 10'd100 : 10'd101;
        end
        check("unstable_held_x", 64'(xpos_out), 64'd799);
        exp_pos(cyc + 5, 10'd101, 10'd599);
        idle(12);
        check("unstable_drained", 64'(exp_q.size()), 64'd0);

        // Short glitch on the left button
        @(negedge clk);
        btn_in[BTN_LEFT] = 1'b1;
        idle(3);
        btn_in[BTN_LEFT] = 1'b0;
        idle(12);
        check("glitch_level", 64'(btn_out), 64'd0);

        // Proper press and release of the left button
        @(negedge clk);
        btn_in[BTN_LEFT] = 1'b1;
        exp_btn(cyc + 6, 2'b01, 2'b01, 2'b00);
        idle(10);
        btn_in[BTN_LEFT] = 1'b0;
        exp_btn(cyc + 6, 2'b00, 2'b00, 2'b01);
        idle(12);
        check("debounce_drained", 64'(exp_q.size()), 64'd0);

        // Concurrent right press and move
        @(negedge clk);
        btn_in[BTN_RIGHT] = 1'b1;
        xpos_in = 10'd400; ypos_in = 10'd300;
        exp_pos(cyc + 5, 10'd400, 10'd300);
        exp_btn(cyc + 6, 2'b10, 2'b10, 2'b00);
        idle(12);
        check("concurrent_level", 64'(btn_out), 64'd2);

        // Set up x=300 with both buttons down, then reset mid-operation
        @(negedge clk);
        xpos_in = 10'd300;
        exp_pos(cyc + 5, 10'd300, 10'd300);
        idle(12);
        @(negedge clk);
        btn_in[BTN_LEFT] = 1'b1;
        exp_btn(cyc + 6, 2'b11, 2'b01, 2'b00);
        idle(12);
        check("pre_reset_state", {xpos_out, btn_out}, {52'd0, 10'd300, 2'b11});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {xpos_out, ypos_out, pos_update, btn_out, btn_press, btn_release}, 64'd0);
        btn_in = 2'b01;
        idle(3);
        rst_n = 1'b1;
        exp_pos(cyc + 5, 10'd300, 10'd300);
        exp_btn(cyc + 6, 2'b01, 2'b01, 2'b00);
        idle(12);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
